// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART FIFO storage RAM.
package uart_fifo_pkg;

   localparam int unsigned DEPTH  = 128;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage : uart_fifo_pkg

// File: rtl/uart_fifo_ram_array.sv
// Bare 128x8 storage: synchronous write port, combinational read port.
module uart_fifo_ram_array
   import uart_fifo_pkg::*;
(
   input  logic  clk,
   input  logic  wr_en,
   input  addr_t waddr,
   input  data_t wdata,
   input  addr_t raddr,
   output data_t rdata_c
);

   data_t mem [DEPTH];

   // No reset on the array: contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_c = mem[raddr];

endmodule : uart_fifo_ram_array

// File: rtl/uart_fifo_ram128x8.sv
// UART FIFO 128x8 RAM: active-low write, registered read address, 1-cycle read.
// Define UART_FIFO_RAM128X8_OUTREG_EN to add an output register (2-cycle read).
module uart_fifo_ram128x8
   import uart_fifo_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] Data,
   input  logic [ADDR_W-1:0] WAddress,
   input  logic [ADDR_W-1:0] RAddress,
   input  logic              WE,
   output logic [DATA_W-1:0] Q
);

   logic  wr_en_c;
   addr_t raddr_d, raddr_q;
   logic  rd_valid_d, rd_valid_q;
   data_t arr_rdata_c;
   data_t rdata_c;

   assign wr_en_c = ~WE;

   uart_fifo_ram_array u_array (
      .clk     (clock),
      .wr_en   (wr_en_c),
      .waddr   (WAddress),
      .wdata   (Data),
      .raddr   (raddr_q),
      .rdata_c (arr_rdata_c)
   );

   // Read data is forced to zero until the first edge after reset.
   always_comb begin
      raddr_d    = RAddress;
      rd_valid_d = 1'b1;
      rdata_c    = rd_valid_q ? arr_rdata_c : data_t'(0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         raddr_q    <= addr_t'(0);
         rd_valid_q <= 1'b0;
      end else begin
         raddr_q    <= raddr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef UART_FIFO_RAM128X8_OUTREG_EN
   data_t q_d, q_q;

   always_comb begin
      q_d = rdata_c;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= data_t'(0);
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;
`else
   assign Q = rdata_c;
`endif

endmodule : uart_fifo_ram128x8

// File: tb/tb_uart_fifo_ram128x8.sv
// Randomized scoreboard bench for uart_fifo_ram128x8 against an array model.
module tb_uart_fifo_ram128x8;

   logic       clock;
   logic       reset;
   logic [7:0] Data;
   logic [6:0] WAddress;
   logic [6:0] RAddress;
   logic       WE;
   logic [7:0] Q;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       k;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] mmem  [128];
   bit         known [128];
   exp_t       pipe1;

   uart_fifo_ram128x8 dut (
      .clock    (clock),
      .reset    (reset),
      .Data     (Data),
      .WAddress (WAddress),
      .RAddress (RAddress),
      .WE       (WE),
      .Q        (Q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: memory written at the edge, read value is the word at the
   // address presented to that same edge (optionally delayed one more edge).
   always @(posedge clock) begin
      exp_t e, n;
      if (!WE) begin
         mmem[WAddress]  = Data;
         known[WAddress] = 1'b1;
      end
      if (reset) begin
         e.d   = 8'h00;
         e.k   = 1'b1;
         pipe1 = e;
      end else begin
         n.d = mmem[RAddress];
         n.k = known[RAddress];
`ifdef UART_FIFO_RAM128X8_OUTREG_EN
         e     = pipe1;
         pipe1 = n;
`else
         e = n;
`endif
      end
      expq.push_back(e);
   end

   // Monitor: one expected value per edge, compared mid-cycle.
   always @(negedge clock) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (e.k) begin
            n_tests++;
            if (Q !== e.d) begin
               n_fail++;
               $display("FAIL q_read t=%0t got=%h expected=%h", $time, Q, e.d);
            end
         end
      end
   end

   task automatic drive(input logic we, input logic [6:0] wa, input logic [7:0] d,
                        input logic [6:0] ra, input logic r);
      @(negedge clock);
      #1;
      WE       = we;
      WAddress = wa;
      Data     = d;
      RAddress = ra;
      reset    = r;
   endtask

   task automatic check_now(input string name, input logic [7:0] exp);
      #1;
      n_tests++;
      if (Q !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, Q, exp);
      end
   endtask

   initial begin
      pipe1.d = 8'h00;
      pipe1.k = 1'b0;
      for (int i = 0; i < 128; i++) known[i] = 1'b0;
      reset = 1'b0; WE = 1'b1; Data = 8'h00; WAddress = 7'd0; RAddress = 7'd0;
      #1 reset = 1'b1;
      check_now("reset_assert", 8'h00);
      drive(1'b1, 7'd9, 8'h11, 7'd3, 1'b1);
      drive(1'b1, 7'd9, 8'h22, 7'd3, 1'b1);

      // Basic write then read back; WE high must not write.
      drive(1'b0, 7'd3, 8'hA5, 7'd3, 1'b1);
      drive(1'b1, 7'd0, 8'h00, 7'd3, 1'b0);
      check_now("reset_release_hold", 8'h00);
      drive(1'b1, 7'd3, 8'hFF, 7'd3, 1'b0);
      drive(1'b1, 7'd3, 8'hFF, 7'd3, 1'b0);
      drive(1'b1, 7'd3, 8'hFF, 7'd3, 1'b0);

      // Full sweep write and consecutive readback with wrap.
      for (int a = 0; a < 128; a++)
         drive(1'b0, 7'(a), 8'(a) ^ 8'h5A, 7'd3, 1'b0);
      for (int a = 0; a < 130; a++)
         drive(1'b1, 7'd0, 8'h00, 7'(a), 1'b0);

      // Collision with RAddress held.
      drive(1'b1, 7'd0, 8'h00, 7'd10, 1'b0);
      drive(1'b0, 7'd10, 8'h3C, 7'd10, 1'b0);
      drive(1'b1, 7'd0, 8'h00, 7'd10, 1'b0);
      drive(1'b1, 7'd0, 8'h00, 7'd10, 1'b0);

      // Reset mid-run: contents retained.
      drive(1'b0, 7'd5, 8'h77, 7'd10, 1'b0);
      drive(1'b1, 7'd0, 8'h00, 7'd10, 1'b0);
      drive(1'b1, 7'd0, 8'h00, 7'd5, 1'b1);
      check_now("reset_mid_run", 8'h00);
      drive(1'b1, 7'd0, 8'h00, 7'd5, 1'b1);
      drive(1'b1, 7'd0, 8'h00, 7'd5, 1'b0);
      check_now("reset_mid_release", 8'h00);
      drive(1'b1, 7'd0, 8'h00, 7'd5, 1'b0);
      drive(1'b1, 7'd0, 8'h00, 7'd5, 1'b0);

      // Streaming: read trails write by 4.
      for (int i = 0; i < 256; i++)
         drive(1'b0, 7'(i), 8'($urandom), 7'(i - 4), 1'b0);

      // Random mix including occasional reset pulses.
      for (int i = 0; i < 200; i++)
         drive(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
               7'($urandom), ($urandom_range(0, 29) == 0));

      drive(1'b1, 7'd0, 8'h00, 7'd3, 1'b0);
      repeat (4) @(negedge clock);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_fifo_ram128x8
